// File: rtl/writeback_queue_if.sv
// Handshake, register-file write and forwarding signals of writeback_queue.
// The slave modport is the queue side; the master modport is the producer/consumer side.
interface writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              write;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_addr_1;
  logic [ADDR_W-1:0] fwd_addr_2;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1;
  logic [DATA_W-1:0] fwd_data_2;
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_addr, in_data, stall, flush, fwd_addr_1, fwd_addr_2,
    output in_ready, write, write_address, write_data,
           fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );

  modport master (
    output in_valid, in_addr, in_data, stall, flush, fwd_addr_1, fwd_addr_2,
    input  in_ready, write, write_address, write_data,
           fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Register write-back FIFO with optional pending-write forwarding.
// Define WBQ_BYPASS_EN to build the forwarding comparators; otherwise fwd_* are tied to 0.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, not_empty;

  assign not_empty         = (count_q != '0);
  assign bus.in_ready      = (count_q != CW'(DEPTH));
  assign bus.write         = not_empty && !bus.stall;
  assign bus.write_address = not_empty ? addr_q[head_q] : '0;
  assign bus.write_data    = not_empty ? data_q[head_q] : '0;
  assign bus.count         = count_q;

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.write && !bus.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= bus.in_addr;
        data_q[tail_q] <= bus.in_data;
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  // Walk from head (oldest) to tail; later matches overwrite, so the youngest wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == a)) r = {1'b1, data_q[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {bus.fwd_hit_1, bus.fwd_data_1} = lookup(bus.fwd_addr_1);
    {bus.fwd_hit_2, bus.fwd_data_2} = lookup(bus.fwd_addr_2);
  end
`else
  assign bus.fwd_hit_1  = 1'b0;
  assign bus.fwd_hit_2  = 1'b0;
  assign bus.fwd_data_1 = '0;
  assign bus.fwd_data_2 = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed and randomized bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  ent_t q[$];

  writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending entry for address a; zero when forwarding is not built.
  task automatic model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WBQ_BYPASS_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == a) begin
        hit = 1'b1;
        d   = q[i].d;
        break;
      end
    end
`endif
  endtask

  task automatic check_all(input string tag);
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;
    int                n;
    n = q.size();
    model_fwd(bus.fwd_addr_1, h1, d1);
    model_fwd(bus.fwd_addr_2, h2, d2);
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(n != DEPTH));
    chk({tag, ".write"}, 32'(bus.write), 32'((n != 0) && !bus.stall));
    chk({tag, ".waddr"}, 32'(bus.write_address), (n != 0) ? 32'(q[0].a) : 32'd0);
    chk({tag, ".wdata"}, 32'(bus.write_data), (n != 0) ? 32'(q[0].d) : 32'd0);
    chk({tag, ".hit1"}, 32'(bus.fwd_hit_1), 32'(h1));
    chk({tag, ".fdata1"}, 32'(bus.fwd_data_1), 32'(d1));
    chk({tag, ".hit2"}, 32'(bus.fwd_hit_2), 32'(h2));
    chk({tag, ".fdata2"}, 32'(bus.fwd_data_2), 32'(d2));
  endtask

  task automatic model_update(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic s, input logic f);
    int n;
    n = q.size();
    if (f) begin
      q.delete();
    end else begin
      if (n != 0 && !s) void'(q.pop_front());
      if (v && n != DEPTH) q.push_back('{a: a, d: d});
    end
  endtask

  // Drive one cycle at least 1 ns after an edge, check before the next edge, then advance.
  task automatic cyc(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic s, input logic f);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.stall    = s;
    bus.flush    = f;
    #1;
    check_all(tag);
    @(posedge clk);
    model_update(v, a, d, s, f);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.fwd_addr_1 = '0;
    bus.fwd_addr_2 = '0;

    #2;
    check_all("reset");
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    #1 rst_n = 1'b1;

    // Single push then write on the following cycle
    cyc("p34.push", 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    chk("p34.write", 32'(bus.write), 32'd1);
    chk("p34.waddr", 32'(bus.write_address), 32'd3);
    chk("p34.wdata", 32'(bus.write_data), 32'h1234);
    cyc("p34.drain", 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("p34.count0", 32'(bus.count), 32'd0);
    chk("p34.write0", 32'(bus.write), 32'd0);

    // Fill under stall, overflow push ignored, then drain in order
    for (int i = 1; i <= 4; i++)
      cyc("p35.fill", 1'b1, ADDR_W'(i), DATA_W'(i * 16'h11), 1'b1, 1'b0);
    chk("p35.full_count", 32'(bus.count), 32'd4);
    chk("p35.full_ready", 32'(bus.in_ready), 32'd0);
    cyc("p35.over", 1'b1, 3'd5, 16'h0055, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b0;
      bus.stall    = 1'b0;
      #1;
      chk("p35.order", 32'(bus.write_address), 32'(i));
      cyc("p35.drain", 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    end
    cyc("p35.empty", 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

    // Flush beats a same-cycle push
    for (int i = 1; i <= 4; i++)
      cyc("p36.fill", 1'b1, ADDR_W'(i), DATA_W'(i), 1'b1, 1'b0);
    cyc("p36.flush", 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk("p36.count", 32'(bus.count), 32'd0);
    chk("p36.write", 32'(bus.write), 32'd0);
    cyc("p36.after", 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

    // Youngest match wins
    cyc("p37.a", 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b0);
    cyc("p37.b", 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0);
    bus.in_valid   = 1'b0;
    bus.fwd_addr_1 = 3'd2;
    bus.fwd_addr_2 = 3'd6;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("p37.hit1", 32'(bus.fwd_hit_1), 32'd1);
    chk("p37.fdata1", 32'(bus.fwd_data_1), 32'h5555);
`else
    chk("p37.hit1", 32'(bus.fwd_hit_1), 32'd0);
    chk("p37.fdata1", 32'(bus.fwd_data_1), 32'd0);
`endif
    chk("p37.hit2", 32'(bus.fwd_hit_2), 32'd0);
    chk("p37.fdata2", 32'(bus.fwd_data_2), 32'd0);
    cyc("p37.flush", 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);

    // Streaming: pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      cyc("p38.stream", 1'b1, i[ADDR_W-1:0], i[DATA_W-1:0], 1'b0, 1'b0);
      chk("p38.count_le1", 32'(bus.count <= 1), 32'd1);
    end
    cyc("p38.drain", 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++)
      cyc("p39.fill", 1'b1, ADDR_W'(i + 4), DATA_W'(16'hC000 + i), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    chk("p39.pre_count", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("p39.count", 32'(bus.count), 32'd0);
    chk("p39.write", 32'(bus.write), 32'd0);
    chk("p39.in_ready", 32'(bus.in_ready), 32'd1);
    check_all("p39.all");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.fwd_addr_1 = ADDR_W'($urandom_range(0, 7));
      bus.fwd_addr_2 = ADDR_W'($urandom_range(0, 7));
      cyc("rand", 1'($urandom_range(0, 9) < 7), ADDR_W'($urandom_range(0, 7)),
          DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of pending write-back entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-003 The block SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  input  1  a write-back request is presented.
REQ-007 The block SHALL have port in_addr  input  ADDR_W  destination register of the request.
REQ-008 The block SHALL have port in_data  input  DATA_W  result value of the request.
REQ-009 The block SHALL have port in_ready  output  1  queue accepts a request this cycle.
REQ-010 The block SHALL have port stall  input  1  register-file write port unavailable this cycle.
REQ-011 The block SHALL have port flush  input  1  discard all pending entries.
REQ-012 The block SHALL have port write  output  1  write strobe to the register file.
REQ-013 The block SHALL have port write_address  output  ADDR_W  register file write address.
REQ-014 The block SHALL have port write_data  output  DATA_W  register file write data.
REQ-015 The block SHALL have ports fwd_addr_1 and fwd_addr_2  input  ADDR_W  register-file read addresses to check for pending writes.
REQ-016 The block SHALL have ports fwd_hit_1 and fwd_hit_2  output  1  a pending entry targets the matching read address.
REQ-017 The block SHALL have ports fwd_data_1 and fwd_data_2  output  DATA_W  value of the youngest matching pending entry.
REQ-018 The block SHALL have port count  output  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-019 The queue SHALL be a FIFO of DEPTH entries {addr, data} with head/tail pointers wrapping modulo DEPTH.
REQ-020 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on stall or on a same-cycle pop.
REQ-021 A push SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-022 write SHALL equal (count != 0) && !stall, combinationally; write_address/write_data SHALL equal the head entry, and be 0 when count == 0.
REQ-023 A pop SHALL occur on every rising edge where write is 1 and flush is 0.
REQ-024 There SHALL be no fall-through: a request pushed at edge N SHALL be written no earlier than the cycle following edge N.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Flush SHALL have priority over push and pop: count becomes 0 at the edge; write remains combinationally valid during the flush cycle.
REQ-027 Forwarding SHALL search all pending entries, including the head being written this cycle; the youngest match SHALL win; same-cycle in_* requests SHALL NOT be matched.
REQ-028 fwd_data_n SHALL be 0 when fwd_hit_n is 0.

Reset
REQ-029 While rst_n is low, count, both pointers, and all entry contents SHALL be 0, so write = 0, in_ready = 1, and fwd_hit_1/2 = 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries immediately, without waiting for a clock edge.
REQ-031 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 With macro WBQ_BYPASS_EN defined, forwarding SHALL behave as described in REQ-027 and REQ-028.
REQ-033 Without WBQ_BYPASS_EN, fwd_hit_1/2 and fwd_data_1/2 SHALL be constant 0 and no comparison logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-034 Push (r3,0x1234) with stall=0 -> next cycle write=1, write_address=3, write_data=0x1234; the cycle after, count=0 and write=0.
REQ-035 Hold stall=1 and push 4 entries (r1..r4, 0x0011..0x0044) -> count=4, in_ready=0; a 5th push is ignored; release stall -> 4 writes in push order on consecutive cycles.
REQ-036 With count=4 and stall=1, pulse flush -> count=0 and write=0 next cycle; a push of (r5,0xBEEF) in the flush cycle is discarded.
REQ-037 With WBQ_BYPASS_EN and stall=1, push (r2,0xAAAA) then (r2,0x5555); fwd_addr_1=2 -> fwd_hit_1=1, fwd_data_1=0x5555; fwd_addr_2=6 -> fwd_hit_2=0, fwd_data_2=0.
REQ-038 Push continuously with stall=0 for 20 cycles, data=cycle index -> count stays <=1 after the first write, writes in order, and pointers wrap correctly.
REQ-039 Drop rst_n asynchronously with count=3 -> write=0, count=0, in_ready=1 before the next edge.
